// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - multiplexed 7-segment scanner with frame-synchronous display update
// Shadow/pending capture keeps a frame from tearing; outputs lag the scan state by one cycle.
module seg_scan_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD          = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int LZ_SUPPRESS    = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank,
  output logic [6:0]              sseg,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRESC = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
  localparam logic [6:0]    SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow_val;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [4*NUM_DIGITS-1:0] r_disp_val;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic                    r_pending;

  logic                  w_tc;
  logic                  w_wrap;
  logic [3:0]            w_nib;
  logic                  w_dp;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [NUM_DIGITS-1:0] w_nz;
  logic                  w_lz_blank;
  logic [6:0]            w_seg;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h58;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign w_tc   = (r_presc == LAST_PRESC);
  assign w_wrap = w_tc && (r_idx == LAST_IDX);

  always_comb begin
    w_nib    = '0;
    w_dp     = 1'b0;
    w_onehot = '0;
    w_nz     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_nz[i] = |r_disp_val[4*i +: 4];
      if (r_idx == IW'(i)) begin
        w_nib       = r_disp_val[4*i +: 4];
        w_dp        = r_disp_dp[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero.
  assign w_lz_blank = (LZ_SUPPRESS != 0) && (r_idx != '0) && ((w_nz >> r_idx) == '0);
  assign w_seg      = w_lz_blank ? 7'h00 : hex7(w_nib);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_pending    <= 1'b0;
      frame_done   <= 1'b0;
      sseg         <= SEG_OFF;
      dp_out       <= (SEG_ACTIVE_LOW != 0);
      dig_en       <= DIG_OFF;
    end else begin
      r_presc    <= w_tc ? '0 : r_presc + 1'b1;
      frame_done <= w_wrap;
      if (w_tc) begin
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
      if (load) begin
        r_shadow_val <= value;
        r_shadow_dp  <= dp_in;
      end
      // A load coinciding with the frame boundary bypasses the shadow.
      if (w_wrap) begin
        if (load) begin
          r_disp_val <= value;
          r_disp_dp  <= dp_in;
        end else if (r_pending) begin
          r_disp_val <= r_shadow_val;
          r_disp_dp  <= r_shadow_dp;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
      sseg   <= (SEG_ACTIVE_LOW != 0) ? ~w_seg : w_seg;
      dp_out <= (SEG_ACTIVE_LOW != 0) ? ~w_dp : w_dp;
      dig_en <= (blank || (r_presc < GUARD_END)) ? DIG_OFF :
                ((DIG_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot);
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - scoreboard bench for seg_scan_mux with a time-based reference model
module tb_seg_scan_mux;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int G  = 2;
  localparam int FR = ND * RD;

  localparam logic [6:0] SEG_LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71};

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        load    = 1'b0;
  logic        blank   = 1'b0;
  logic [15:0] value   = '0;
  logic [3:0]  dp_in   = '0;
  logic [6:0]  sseg;
  logic        dp_out;
  logic [3:0]  dig_en;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_mux #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(G),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1), .LZ_SUPPRESS(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .value(value), .dp_in(dp_in), .blank(blank),
    .sseg(sseg), .dp_out(dp_out), .dig_en(dig_en), .frame_done(frame_done)
  );

  typedef struct packed {
    logic [6:0] sseg;
    logic       dp;
    logic [3:0] dig;
    logic       fd;
  } exp_t;

  exp_t        q[$];
  int          m_t;
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_disp_dp, m_shadow_dp;
  bit          m_pend;
  int          m_pres, m_slot;
  logic [3:0]  m_nib;
  exp_t        m_e;
  int          n_pass  = 0;
  int          n_total = 0;
  int          n_cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: scan position follows from elapsed cycles since reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_t = 0; m_disp = '0; m_shadow = '0; m_disp_dp = '0; m_shadow_dp = '0; m_pend = 0;
      q.delete();
    end else begin
      m_pres  = m_t % RD;
      m_slot  = (m_t / RD) % ND;
      m_nib   = m_disp[4*m_slot +: 4];
      m_e.sseg = (m_slot > 0 && (m_disp >> (4*m_slot)) == 0) ? 7'h00 : SEG_LUT[m_nib];
      m_e.dp   = m_disp_dp[m_slot];
      m_e.dig  = (m_pres < G || blank) ? 4'hF : ~(4'b0001 << m_slot);
      m_e.fd   = (m_t % FR == FR - 1);
      q.push_back(m_e);
      if (m_t % FR == FR - 1) begin
        if (load) begin
          m_disp = value; m_disp_dp = dp_in;
        end else if (m_pend) begin
          m_disp = m_shadow; m_disp_dp = m_shadow_dp;
        end
        m_pend = 0;
      end else if (load) begin
        m_shadow = value; m_shadow_dp = dp_in; m_pend = 1;
      end
      m_t++;
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_sseg", 32'(sseg), 32'h00);
      check("rst_dp_out", 32'(dp_out), 32'h0);
      check("rst_dig_en", 32'(dig_en), 32'hF);
      check("rst_frame_done", 32'(frame_done), 32'h0);
    end else if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("sseg", 32'(sseg), 32'(mon_e.sseg));
      check("dp_out", 32'(dp_out), 32'(mon_e.dp));
      check("dig_en", 32'(dig_en), 32'(mon_e.dig));
      check("frame_done", 32'(frame_done), 32'(mon_e.fd));
      n_cyc++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_frame_pos(input int p);
    for (int i = 0; i < FR; i++) begin
      if (m_t % FR == p) break;
      tick(1);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; value = v; dp_in = d;
    tick(1);
    load = 1'b0;
  endtask

  logic [15:0] mask;
  initial begin
    tick(3);
    #2 reset_n = 1'b1;
    tick(FR * 2);

    tick(5);
    do_load(16'h12AF, 4'b0100);
    tick(FR * 2);

    wait_frame_pos(3);
    do_load(16'h0001, 4'b0000);
    tick(5);
    do_load(16'h0F00, 4'b0000);
    tick(FR * 2);

    wait_frame_pos(10);
    do_load(16'h1234, 4'b0001);
    wait_frame_pos(FR - 1);
    do_load(16'h8888, 4'b1000);
    tick(FR * 3);

    blank = 1'b1;
    tick(FR + 5);
    blank = 1'b0;
    tick(FR);

    wait_frame_pos(12);
    do_load(16'h5555, 4'b1111);
    tick(2);
    #2 reset_n = 1'b0;
    tick(2);
    #2 reset_n = 1'b1;
    tick(FR * 2);

    repeat (3000) begin
      case ($urandom_range(0, 3))
        0: mask = 16'h000F;
        1: mask = 16'h00FF;
        2: mask = 16'h0FFF;
        default: mask = 16'hFFFF;
      endcase
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom) & mask;
      dp_in = 4'($urandom);
      if ($urandom_range(0, 63) == 0) blank = ~blank;
      tick(1);
    end
    load = 1'b0;
    blank = 1'b0;
    tick(4);

    check("cycles_checked", 32'(n_cyc > 3000), 32'h1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000: clk cycles per digit slot; legal minimum GUARD+2.
REQ-003 Parameter GUARD, default 2: cycles at slot start with all digit enables inactive (anti-ghosting).
REQ-004 Parameter SEG_ACTIVE_LOW, default 0: 1 inverts sseg and dp_out polarity.
REQ-005 Parameter DIG_ACTIVE_LOW, default 1: 1 makes dig_en active-low.
REQ-006 Parameter LZ_SUPPRESS, default 1: enables leading-zero blanking.
REQ-007 clk  input  1  sole clock; all state changes on the rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 load  input  1  capture strobe for value/dp_in.
REQ-010 value  input  4*NUM_DIGITS  hex digits; nibble i drives digit i; digit 0 is least significant.
REQ-011 dp_in  input  NUM_DIGITS  decimal point request per digit.
REQ-012 blank  input  1  level; forces all digit enables inactive while high.
REQ-013 sseg  output  7  segments, bit6=g .. bit0=a, registered.
REQ-014 dp_out  output  1  decimal point for the active digit, registered.
REQ-015 dig_en  output  NUM_DIGITS  one-hot digit enable, registered.
REQ-016 frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-017 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; the terminal count SHALL advance the slot index.
REQ-018 The slot index SHALL step 0,1,..,NUM_DIGITS-1 and wrap to 0.
REQ-019 frame_done SHALL be high for exactly the cycle after the edge on which the index wraps from NUM_DIGITS-1 to 0.
REQ-020 A load sampled high SHALL capture value/dp_in into a shadow register and set a pending flag.
REQ-021 On the frame-boundary edge the display register SHALL take the shadow if pending, then clear pending; mid-frame loads never alter the display register (no tearing).
REQ-022 A load on the frame-boundary edge itself SHALL transfer the newly presented value/dp_in directly to the display register, leaving pending clear.
REQ-023 Back-to-back loads within one frame SHALL keep only the last.
REQ-024 Decode, active-high, hex: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=58 D=5E E=79 F=71; SEG_ACTIVE_LOW SHALL invert all 7 bits.
REQ-025 With LZ_SUPPRESS=1, digit i>0 SHALL show all segments off when it and every higher digit are zero; digit 0 is never suppressed; dp_out is unaffected by suppression.
REQ-026 dig_en SHALL be all-inactive when prescaler < GUARD, or when blank=1; otherwise only bit [index] active.
REQ-027 sseg, dp_out and dig_en SHALL be registered, lagging the prescaler/index state by exactly one cycle.
REQ-028 For NUM_DIGITS=1 the index SHALL stay 0 and frame_done SHALL pulse once per REFRESH_DIV cycles.

Reset
REQ-029 While reset_n=0: prescaler=0, index=0, shadow=0, display register=0, pending=0, frame_done=0.
REQ-030 While reset_n=0: sseg all segments off, dp_out off, dig_en all inactive, in configured polarity.
REQ-031 Reset asserted mid-frame or mid-load SHALL discard pending data.
REQ-032 After release, the first slot SHALL be digit 0 showing "0" (3F) following GUARD inactive cycles.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2, defaults otherwise)
REQ-033 Reset release, no load -> dig_en=1111 for 3 cycles, then 1110 with sseg=3F for 6 cycles; digits 1..3 stay blank (LZ).
REQ-034 load value=16'h12AF, dp_in=4'b0100 mid-frame -> unchanged until frame_done, next frame shows 71,77,5B(dp on),06 on digits 0..3.
REQ-035 Two loads 16'h0001 then 16'h0F00 in one frame -> next frame shows only 0F00: digit0=3F, digit1=3F, digit2=71, digit3 suppressed.
REQ-036 load 16'h8888 on frame-boundary edge -> next frame shows 7F on all digits, pending clear.
REQ-037 blank=1 for a full frame -> dig_en=1111 throughout, frame_done still pulses every 32 cycles.
REQ-038 reset_n pulsed low mid-slot with load pending -> outputs inactive at once; after release display shows "0", pending data lost.
